waypoint_direction_fsm: RTL and testbench

- Parametrised successor to the robot direction controller.
- Drives the waiter robot from base out to one of N_TABLES tables along a single line of waypoint markers, then back to base.
- Inputs are debounced microphone-frequency trigger samples, ultrasonic distance samples and the red-pixel count, sampled on explicit valid strobes.
- Adds an emergency-stop state, a programmable minimum-travel timer, and per-leg table counting.
- Sits between the sensor front-ends (mic FFT peak, ultrasonic ranger, colour counter) and the motor driver, which decodes `direction`.

---
 rtl/waypoint_direction_fsm.sv | 152 +++++++++++++++
 tb/tb_waypoint_direction_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/waypoint_direction_fsm.sv
// rtl/waypoint_direction_fsm.sv - waiter robot waypoint FSM: base -> table -> base with
// filtered mic trigger, filtered obstacle range, red-stop, e-stop and minimum-travel timer.
module waypoint_direction_fsm #(
  parameter int FREQ_W            = 10,
  parameter int DIST_W            = 8,
  parameter int PIX_W             = 17,
  parameter int MIC_DEPTH         = 4,
  parameter int DIST_DEPTH        = 2,
  parameter int TOO_CLOSE         = 30,
  parameter int MIN_TRAVEL_CYCLES = 50000000,
  parameter int N_TABLES          = 4,
  localparam int TBL_W            = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] frequency_input,
  input  logic              frequency_valid,
  input  logic [FREQ_W-1:0] threshold_frequency,
  input  logic [DIST_W-1:0] distance,
  input  logic              distance_valid,
  input  logic [PIX_W-1:0]  red_pixels,
  input  logic [PIX_W-1:0]  threshold_pixels,
  input  logic [TBL_W-1:0]  table_sel,
  input  logic              estop,
  output logic [2:0]        direction,
  output logic [TBL_W-1:0]  current_table,
  output logic              arrived
);

  localparam int TMR_W = (MIN_TRAVEL_CYCLES > 0) ? $clog2(MIN_TRAVEL_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(MIN_TRAVEL_CYCLES);
  localparam logic [TBL_W-1:0]  LAST_TBL  = TBL_W'(N_TABLES - 1);
  localparam logic [DIST_W-1:0] CLOSE_LIM = DIST_W'(TOO_CLOSE);

  typedef enum logic [2:0] {
    IDLE_BASE  = 3'b000,
    FORWARDS   = 3'b001,
    IDLE_TABLE = 3'b010,
    BACKWARDS  = 3'b011,
    STOP       = 3'b100
  } state_t;

  state_t            state, state_next;
  logic [TBL_W-1:0]  table_q, table_next, target, sel_clamped;
  logic [TMR_W-1:0]  timer;
  logic [FREQ_W-1:0] mic_sr  [MIC_DEPTH];
  logic [DIST_W-1:0] dist_sr [DIST_DEPTH];
  logic              threshold_reached, too_close, red_stop, timer_done, arrive;
  logic              waypoint_pass, arrive_pulse, state_change, moving;

  generate
    if ((2 ** TBL_W) > N_TABLES) begin : g_clamp
      assign sel_clamped = (table_sel > LAST_TBL) ? LAST_TBL : table_sel;
    end else begin : g_pass
      assign sel_clamped = table_sel;
    end
  endgenerate

  always_comb begin
    threshold_reached = 1'b1;
    for (int i = 0; i < MIC_DEPTH; i++)
      if (mic_sr[i] < threshold_frequency) threshold_reached = 1'b0;
    too_close = 1'b1;
    for (int i = 0; i < DIST_DEPTH; i++)
      if (dist_sr[i] > CLOSE_LIM) too_close = 1'b0;
  end

  assign red_stop     = red_pixels > threshold_pixels;
  assign timer_done   = (timer == TMR_MAX);
  assign arrive       = (too_close && timer_done) || red_stop;
  assign moving       = (state == FORWARDS) || (state == BACKWARDS);
  assign state_change = (state_next != state);

  always_comb begin
    state_next    = state;
    table_next    = table_q;
    waypoint_pass = 1'b0;
    arrive_pulse  = 1'b0;
    if (estop) begin
      state_next = STOP;
    end else begin
      case (state)
        IDLE_BASE: if (threshold_reached) begin
          state_next = FORWARDS;
          table_next = '0;
        end
        FORWARDS: if (arrive) begin
          if (table_q == target) begin
            state_next   = IDLE_TABLE;
            arrive_pulse = 1'b1;
          end else begin
            table_next    = table_q + 1'b1;
            waypoint_pass = 1'b1;
          end
        end
        IDLE_TABLE: if (threshold_reached) state_next = BACKWARDS;
        BACKWARDS: if (too_close && timer_done) begin
          state_next = IDLE_BASE;
          table_next = '0;
        end
        STOP: if (threshold_reached) begin
          state_next = IDLE_BASE;
          table_next = '0;
        end
        default: state_next = STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE_BASE;
      table_q <= '0;
      target  <= '0;
      arrived <= 1'b0;
      timer   <= '0;
    end else begin
      state   <= state_next;
      table_q <= table_next;
      arrived <= arrive_pulse;
      if (state == IDLE_BASE && state_next == FORWARDS) target <= sel_clamped;
      // Each leg and each waypoint gets its own full minimum-travel window.
      if (!moving || state_change || waypoint_pass) timer <= '0;
      else if (!timer_done)                         timer <= timer + 1'b1;
    end
  end

  // Flushing on every state change keeps one whistle from firing two transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MIC_DEPTH; i++) mic_sr[i] <= '0;
    end else if (state_change) begin
      for (int i = 0; i < MIC_DEPTH; i++) mic_sr[i] <= '0;
    end else if (frequency_valid) begin
      mic_sr[0] <= frequency_input;
      for (int i = 1; i < MIC_DEPTH; i++) mic_sr[i] <= mic_sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIST_DEPTH; i++) dist_sr[i] <= '1;
    end else if (distance_valid) begin
      dist_sr[0] <= distance;
      for (int i = 1; i < DIST_DEPTH; i++) dist_sr[i] <= dist_sr[i-1];
    end
  end

  assign direction     = state;
  assign current_table = table_q;

endmodule

// File: tb/tb_waypoint_direction_fsm.sv
// tb/tb_waypoint_direction_fsm.sv - scoreboard bench for waypoint_direction_fsm against a
// queue-based behavioural model of the robot's trip rules.
module tb_waypoint_direction_fsm;
  localparam int MIN = 16;
  localparam int MD  = 4;
  localparam int DD  = 2;
  localparam int NT  = 4;
  localparam int TC  = 30;
  localparam int M_IB = 0, M_FW = 1, M_IT = 2, M_BW = 3, M_ST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  frequency_input = '0;
  logic        frequency_valid = 1'b0;
  logic [9:0]  threshold_frequency = 10'd15;
  logic [7:0]  distance = '0;
  logic        distance_valid = 1'b0;
  logic [16:0] red_pixels = '0;
  logic [16:0] threshold_pixels = 17'd100;
  logic [1:0]  table_sel = '0;
  logic        estop = 1'b0;
  logic [2:0]  direction;
  logic [1:0]  current_table;
  logic        arrived;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  waypoint_direction_fsm #(
    .FREQ_W(10), .DIST_W(8), .PIX_W(17), .MIC_DEPTH(MD), .DIST_DEPTH(DD),
    .TOO_CLOSE(TC), .MIN_TRAVEL_CYCLES(MIN), .N_TABLES(NT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frequency_input(frequency_input), .frequency_valid(frequency_valid),
    .threshold_frequency(threshold_frequency),
    .distance(distance), .distance_valid(distance_valid),
    .red_pixels(red_pixels), .threshold_pixels(threshold_pixels),
    .table_sel(table_sel), .estop(estop),
    .direction(direction), .current_table(current_table), .arrived(arrived)
  );

  // Reference model: trip mode, waypoint count, travel time and the recent sample windows.
  int m_mode, m_ct, m_target, m_timer;
  int unsigned mic_q[$];
  int unsigned dist_q[$];
  logic [5:0] exp_q[$];

  task automatic model_reset();
    m_mode = M_IB; m_ct = 0; m_target = 0; m_timer = 0;
    mic_q.delete();  repeat (MD) mic_q.push_back(0);
    dist_q.delete(); repeat (DD) dist_q.push_back(255);
    exp_q.delete();
  endtask

  task automatic model_step();
    bit trig, close, red, tdone, wp, arr;
    int nm, nct;
    trig = 1'b1;  foreach (mic_q[i])  if (mic_q[i] < threshold_frequency) trig = 1'b0;
    close = 1'b1; foreach (dist_q[i]) if (dist_q[i] > TC) close = 1'b0;
    red   = red_pixels > threshold_pixels;
    tdone = (m_timer == MIN);
    nm = m_mode; nct = m_ct; wp = 1'b0; arr = 1'b0;
    if (estop) nm = M_ST;
    else case (m_mode)
      M_IB: if (trig) begin
        nm = M_FW; nct = 0;
        m_target = (int'(table_sel) > NT - 1) ? NT - 1 : int'(table_sel);
      end
      M_FW: if ((close && tdone) || red) begin
        if (m_ct == m_target) begin nm = M_IT; arr = 1'b1; end
        else begin nct = m_ct + 1; wp = 1'b1; end
      end
      M_IT: if (trig) nm = M_BW;
      M_BW: if (close && tdone) begin nm = M_IB; nct = 0; end
      default: if (trig) begin nm = M_IB; nct = 0; end
    endcase
    if ((m_mode == M_FW || m_mode == M_BW) && nm == m_mode && !wp)
      m_timer = (m_timer < MIN) ? m_timer + 1 : MIN;
    else
      m_timer = 0;
    if (nm != m_mode) begin
      mic_q.delete(); repeat (MD) mic_q.push_back(0);
    end else if (frequency_valid) begin
      void'(mic_q.pop_front()); mic_q.push_back(int'(frequency_input));
    end
    if (distance_valid) begin
      void'(dist_q.pop_front()); dist_q.push_back(int'(distance));
    end
    m_mode = nm; m_ct = nct;
    exp_q.push_back({3'(nm), 2'(nct), arr});
  endtask

  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({direction, current_table, arrived} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: dir=%b tbl=%0d arr=%b, expected dir=%b tbl=%0d arr=%b",
                 $time, direction, current_table, arrived, e[5:3], e[2:1], e[0]);
      end
    end
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe_f(input int v);
    frequency_input = 10'(v); frequency_valid = 1'b1; tick(); frequency_valid = 1'b0;
  endtask

  task automatic strobe_d(input int v);
    distance = 8'(v); distance_valid = 1'b1; tick(); distance_valid = 1'b0;
  endtask

  task automatic whistle();
    repeat (MD) strobe_f(20);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_eq("reset_direction", int'(direction), 0);
    check_eq("reset_table", int'(current_table), 0);
    check_eq("reset_arrived", int'(arrived), 0);
    rst_n = 1'b1;

    // Mic filter: one weak sample blocks the trigger, four strong ones fire it.
    strobe_f(20); strobe_f(20); strobe_f(20); strobe_f(10);
    idle(3);
    table_sel = 2'd2;
    whistle();
    idle(17);
    // Three obstacle arrivals to reach table 2.
    for (int k = 0; k < 3; k++) begin
      strobe_d(25); strobe_d(25);
      strobe_d(255); strobe_d(255);
      idle(17);
    end
    whistle();
    red_pixels = 17'd200; idle(5); red_pixels = 17'd0;
    idle(17);
    strobe_d(20); strobe_d(20);
    idle(3);

    // Early obstacle is ignored, red stop ends the leg at once.
    strobe_d(255); strobe_d(255);
    table_sel = 2'd0;
    whistle();
    idle(4);
    strobe_d(10); strobe_d(10);
    idle(1);
    red_pixels = 17'd200; tick(); red_pixels = 17'd0;
    idle(3);
    whistle();
    idle(20);

    // Emergency stop against a same-cycle arrival, then mic while held.
    strobe_d(255); strobe_d(255);
    table_sel = 2'd1;
    whistle();
    idle(17);
    strobe_d(10);
    estop = 1'b1; strobe_d(10);
    whistle();
    estop = 1'b0; idle(3);
    estop = 1'b1; idle(4);
    estop = 1'b0; idle(3);
    whistle();
    idle(3);

    // Asynchronous reset mid-trip with current_table at 1.
    strobe_d(255); strobe_d(255);
    table_sel = 2'd3;
    whistle();
    idle(17);
    strobe_d(25); strobe_d(25);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_direction", int'(direction), 0);
    check_eq("async_rst_table", int'(current_table), 0);
    check_eq("async_rst_arrived", int'(arrived), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    table_sel = 2'd0;
    whistle();
    idle(17);
    strobe_d(10);
    idle(5);
    strobe_d(10);
    idle(3);

    // Randomised traffic around every threshold boundary.
    for (int c = 0; c < 3000; c++) begin
      frequency_valid = ($urandom_range(0, 2) == 0);
      frequency_input = 10'($urandom_range(10, 25));
      distance_valid  = ($urandom_range(0, 5) == 0);
      distance        = 8'($urandom_range(20, 40));
      case ($urandom_range(0, 39))
        0:       red_pixels = 17'd101;
        1:       red_pixels = 17'd200;
        2, 3:    red_pixels = 17'd100;
        default: red_pixels = 17'd50;
      endcase
      table_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) estop = ~estop;
      tick();
    end
    frequency_valid = 1'b0; distance_valid = 1'b0; estop = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
